dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for core load/store requests over a valid/ready
//  request channel and a valid/ready response channel. Owns a word-organised
//  data RAM and performs byte, half and word accesses with RV32I load/store
//  semantics, including sign/zero extension, byte lanes and error reporting.
//  Sits between the core datapath's memory stage and on-chip data storage;
//  WAIT_CYCLES models slower memory.
// PARAMETERS
//  DEPTH_WORDS  256           RAM depth in 32-bit words
//  WAIT_CYCLES  1             extra cycles between request accept and response (0..15)
//  ADDR_BASE    32'h00000000  byte address mapped to word 0
// PORTS
//  clock        in   1   system clock, rising edge
//  resetn       in   1   asynchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept a request
//  req_we       in   1   1=store, 0=load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned
//  req_funct3   in   3   RV32I funct3 (access size/sign)
//  resp_valid   out  1   response present
//  resp_ready   in   1   core accepts response
//  resp_rdata   out  32  load result, extended; 0 for stores/errors
//  resp_err     out  1   misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0; resp_valid=0; resp_rdata=0; resp_err=0.
//   req_ready is registered and rises on the first clock edge after resetn is
//   released. RAM contents are not reset and are retained across reset.
//  FSM: IDLE -> (accept) -> WAIT (if WAIT_CYCLES>0) -> RESP -> (resp handshake) -> IDLE.
//  - IDLE: req_ready=1. Accept on req_valid&&req_ready edge; latch we/addr/wdata/funct3.
//    Clear req_ready. Load wait counter with WAIT_CYCLES. Go to WAIT, or to RESP if 0.
//  - WAIT: decrement the counter each cycle; at 1, move to RESP on the next edge.
//  - The RAM access and the store commit occur on the edge entering RESP.
//    resp_valid, resp_rdata and resp_err are registered on that same edge.
//    Latency: resp_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge.
//  - RESP: hold resp_valid/rdata/err stable until resp_ready. On handshake,
//    resp_valid=0 and req_ready=1 (back to IDLE). There is no accept in the same
//    cycle. Throughput: one request per WAIT_CYCLES+2 cycles minimum.
//  Decode, little-endian:
//   - idx = (addr-ADDR_BASE)>>2.
//   - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
//   - Any other funct3 is illegal.
//   - SB writes wdata[7:0] to lane addr[1:0]. SH writes wdata[15:0] to lanes
//     {addr[1],0}+1:0. Other lanes are unchanged.
//   - LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend.
//  Errors (resp_err=1, rdata=0, RAM untouched):
//   - halfword with addr[0]=1; word with addr[1:0]!=0;
//   - addr<ADDR_BASE or idx>=DEPTH_WORDS;
//   - illegal funct3.
//   Errored requests still complete the full handshake with normal latency.
//  Inputs other than req_valid are don't-care outside an accept cycle.
//  Reset mid-operation: a pending request is dropped and no response is issued.
//   A store whose commit edge has not occurred is not written.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0; resp_valid
//     rises 2 cycles after accept (WAIT_CYCLES=1).
//  2. SB 0x80 @0x21 over word 0x11223344 -> LW @0x20 = 0x11228044;
//     LB @0x21 = 0xFFFFFF80; LBU @0x21 = 0x00000080.
//  3. LH @0x03, SW @0x06, funct3=011, addr=4*DEPTH_WORDS -> err=1, rdata=0;
//     a following LW of the target word is unchanged.
//  4. resp_ready held low 5 cycles -> resp_valid/rdata stable; req_ready=0
//     throughout; a new req_valid is not accepted.
//  5. resetn pulsed low the cycle after a SW accept -> no resp_valid;
//     req_ready=0 during reset, 1 on the first edge after release; word unchanged.
//  6. WAIT_CYCLES=0 back-to-back LW stream -> one response every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Memory-side responder for RV32I load/store requests: owns a word-organised
// data RAM behind valid/ready request and response channels.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h00000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic DIRECT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        write_en;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic [31:0] word_idx;
  logic [AW-1:0] ram_idx;
  logic        in_range;
  logic        legal;
  logic        misaligned;
  logic        err;
  logic [31:0] old_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [31:0] rsp_data;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign commit = (DIRECT && accept) || ((state == WAIT) && (count == 4'd1));

  // With no wait states the access happens on the accept edge itself, so
  // decode straight from the request inputs while idle.
  always_comb begin
    cur_we     = lat_we;
    cur_addr   = lat_addr;
    cur_wdata  = lat_wdata;
    cur_funct3 = lat_funct3;
    if (state == IDLE) begin
      cur_we     = req_we;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
      cur_funct3 = req_funct3;
    end
  end

  always_comb begin
    word_idx = (cur_addr - ADDR_BASE) >> 2;
    ram_idx  = word_idx[AW-1:0];
    in_range = (cur_addr >= ADDR_BASE) && (word_idx < 32'(DEPTH_WORDS));

    legal = 1'b0;
    case (cur_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !cur_we;
      default:                legal = 1'b0;
    endcase

    misaligned = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                 ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    err = !legal || misaligned || !in_range;

    old_word = mem[ram_idx];
    byte_val = old_word[7:0];
    case (cur_addr[1:0])
      2'd0:    byte_val = old_word[7:0];
      2'd1:    byte_val = old_word[15:8];
      2'd2:    byte_val = old_word[23:16];
      default: byte_val = old_word[31:24];
    endcase
    half_val = cur_addr[1] ? old_word[31:16] : old_word[15:0];

    load_data = 32'h0;
    case (cur_funct3)
      3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
      3'b001:  load_data = {{16{half_val[15]}}, half_val};
      3'b010:  load_data = old_word;
      3'b100:  load_data = {24'h0, byte_val};
      3'b101:  load_data = {16'h0, half_val};
      default: load_data = 32'h0;
    endcase

    // Stores merge into the existing word so untouched lanes keep their bytes.
    store_word = old_word;
    case (cur_funct3)
      3'b000: begin
        case (cur_addr[1:0])
          2'd0:    store_word[7:0]   = cur_wdata[7:0];
          2'd1:    store_word[15:8]  = cur_wdata[7:0];
          2'd2:    store_word[23:16] = cur_wdata[7:0];
          default: store_word[31:24] = cur_wdata[7:0];
        endcase
      end
      3'b001: begin
        if (cur_addr[1]) store_word[31:16] = cur_wdata[15:0];
        else             store_word[15:0]  = cur_wdata[15:0];
      end
      3'b010:  store_word = cur_wdata;
      default: store_word = old_word;
    endcase

    rsp_data = (cur_we || err) ? 32'h0 : load_data;
    write_en = commit && cur_we && !err;
  end

  always_ff @(posedge clock) begin
    if (write_en) mem[ram_idx] <= store_word;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      count      <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_funct3 <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            count      <= 4'(WAIT_CYCLES);
            if (DIRECT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rsp_data;
              resp_err   <= err;
            end else begin
              state <= WAIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rsp_data;
            resp_err   <= err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with a wait state, one without.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, req_ready;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        resp_valid, resp_err, resp_ready = 1'b0;
  logic [31:0] resp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, req_ready0;
  logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
  logic [2:0]  req_funct30 = 3'b000;
  logic        resp_valid0, resp_err0, resp_ready0 = 1'b0;
  logic [31:0] resp_rdata0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .ADDR_BASE(32'h0)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut0 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request, returns once resp_valid is seen (or the bound expires).
  // lat counts cycles from the accept cycle to the first cycle with resp_valid.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic takeResponse();
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    applyStimulus(we, addr, wdata, f3, rdata, err, lat);
    checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    checkOutput({tag, "_lat"}, lat, 32'd2);
    takeResponse();
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n;
    logic [31:0] exp_byte;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
    resetn = 1'b1;
    #1 checkOutput("rel_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clock);
    checkOutput("rel_ready_high", {31'b0, req_ready}, 32'd1);

    // Word store then load
    access("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    access("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Byte and half lanes with extension
    access("sw20", 1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0);
    access("sb21", 1'b1, 32'h21, 32'hFFFFFF80, 3'b000, 32'h0, 1'b0);
    access("lw20a", 1'b0, 32'h20, 32'h0, 3'b010, 32'h11228044, 1'b0);
    access("lb21", 1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    access("lbu21", 1'b0, 32'h21, 32'h0, 3'b100, 32'h00000080, 1'b0);
    access("lh22a", 1'b0, 32'h22, 32'h0, 3'b001, 32'h00001122, 1'b0);
    access("sh22", 1'b1, 32'h22, 32'h0000BEEF, 3'b001, 32'h0, 1'b0);
    access("lw20b", 1'b0, 32'h20, 32'h0, 3'b010, 32'hBEEF8044, 1'b0);
    access("lh22b", 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    access("lhu22", 1'b0, 32'h22, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);
    access("lb23", 1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFFFFBE, 1'b0);

    // Error cases leave the RAM untouched
    access("sw04", 1'b1, 32'h04, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0);
    access("lh03", 1'b0, 32'h03, 32'h0, 3'b001, 32'h0, 1'b1);
    access("sw06", 1'b1, 32'h06, 32'h12345678, 3'b010, 32'h0, 1'b1);
    access("f3_011", 1'b1, 32'h04, 32'h12345678, 3'b011, 32'h0, 1'b1);
    access("sbu04", 1'b1, 32'h04, 32'h12345678, 3'b100, 32'h0, 1'b1);
    access("lw400", 1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b1);
    access("lw04", 1'b0, 32'h04, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0);
    access("sw3fc", 1'b1, 32'h3FC, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    access("lw3fc", 1'b0, 32'h3FC, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

    // Backpressure: response held, no new accept
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, rdata, err, lat);
    checkOutput("bp_lat", lat, 32'd2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("bp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("bp_rdata", resp_rdata, 32'hDEADBEEF);
      checkOutput("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    takeResponse();
    checkOutput("bp_after_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("bp_after_ready", {31'b0, req_ready}, 32'd1);
    access("bp_lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Reset between accept and commit drops the store
    access("sw40", 1'b1, 32'h40, 32'h01234567, 3'b010, 32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF; req_funct3 = 3'b010;
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("mid_rst_valid2", {31'b0, resp_valid}, 32'd0);
    resetn = 1'b1;
    #1 checkOutput("mid_rel_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clock);
    checkOutput("mid_rel_ready_high", {31'b0, req_ready}, 32'd1);
    checkOutput("mid_rel_valid", {31'b0, resp_valid}, 32'd0);
    access("lw40", 1'b0, 32'h40, 32'h0, 3'b010, 32'h01234567, 1'b0);

    // Zero wait states: streaming with one response every two cycles
    n = 0;
    while (!req_ready0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'hCAFEF00D;
    req_funct30 = 3'b010; resp_ready0 = 1'b1;
    @(negedge clock);
    checkOutput("w0_store_valid", {31'b0, resp_valid0}, 32'd1);
    checkOutput("w0_store_err", {31'b0, resp_err0}, 32'd0);
    req_we0 = 1'b0; req_funct30 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      req_addr0 = 32'h8 + 32'(i);
      exp_byte = (i == 0) ? 32'h0D : (i == 1) ? 32'hF0 : 32'hFE;
      @(negedge clock);
      checkOutput("w0_gap", {31'b0, resp_valid0}, 32'd0);
      @(negedge clock);
      checkOutput("w0_load_valid", {31'b0, resp_valid0}, 32'd1);
      checkOutput("w0_load_data", resp_rdata0, exp_byte);
    end
    req_valid0 = 1'b0;
    @(negedge clock);
    resp_ready0 = 1'b0;
    checkOutput("w0_idle", {31'b0, resp_valid0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
